// File: rtl/bram_stream_fifo_ctrl_pkg.sv
// Shared constants and math helpers for the BRAM streaming FIFO controller.
package bram_stream_fifo_ctrl_pkg;

  localparam int STAGE_DEPTH = 2;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry show-ahead output stage: registered head word, one tail slot behind it.
module stream_skid_buf2
  import bram_stream_fifo_ctrl_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [C_DATA_WIDTH-1:0] wr_data,
  output logic                    rd_valid,
  output logic [C_DATA_WIDTH-1:0] rd_data,
  input  logic                    rd_ready,
  output logic [1:0]              cnt
);

  logic [C_DATA_WIDTH-1:0] head_q;
  logic [C_DATA_WIDTH-1:0] tail_q;
  logic [1:0]              cnt_q;
  logic                    pop;

  assign pop      = rd_valid && rd_ready;
  assign rd_valid = (cnt_q != 2'd0);
  assign rd_data  = head_q;
  assign cnt      = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
    end else begin
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Data slots carry no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (pop && (cnt_q == 2'(STAGE_DEPTH))) begin
      head_q <= tail_q;
      if (wr_en) tail_q <= wr_data;
    end else if (wr_en) begin
      if ((cnt_q == 2'd0) || pop) head_q <= wr_data;
      else                        tail_q <= wr_data;
    end
  end

endmodule

// File: rtl/bram_stream_fifo_ctrl.sv
// Valid/ready FIFO controller around a registered-read simple-dual-port BRAM,
// with a 2-entry show-ahead stage hiding the one-cycle read latency.
module bram_stream_fifo_ctrl
  import bram_stream_fifo_ctrl_pkg::*;
#(
  parameter  int C_DATA_WIDTH  = 64,
  parameter  int C_RAM_DEPTH   = 512,
  parameter  int C_ALMOST_FULL = C_RAM_DEPTH - 4,
  localparam int AW            = clog2(C_RAM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din_valid,
  input  logic [C_DATA_WIDTH-1:0] din,
  output logic                    din_ready,
  output logic                    dout_valid,
  output logic [C_DATA_WIDTH-1:0] dout,
  input  logic                    dout_ready,
  output logic [AW-1:0]           ram_wrAddr,
  output logic [C_DATA_WIDTH-1:0] ram_datain,
  output logic                    ram_wren,
  output logic [AW-1:0]           ram_rdAddr,
  output logic                    ram_rden,
  input  logic [C_DATA_WIDTH-1:0] ram_dataout,
  output logic [AW+1:0]           count,
  output logic                    full,
  output logic                    almost_full,
  output logic                    empty
);

  localparam logic [AW:0]   RAM_FULL = (AW+1)'(C_RAM_DEPTH);
  localparam logic [AW+1:0] AF_LEVEL = (AW+2)'(C_ALMOST_FULL);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   ram_cnt;
  logic          inflight;
  logic [1:0]    stage_cnt;
  logic [2:0]    stage_occ;
  logic          push;
  logic          pop;

  // ram_cnt counts only completed writes, so a read never targets the word
  // being written this cycle, and freeing a slot never feeds din_ready combinationally.
  assign din_ready  = !rst && (ram_cnt != RAM_FULL);
  assign push       = din_valid && din_ready;
  assign pop        = dout_valid && dout_ready;
  assign stage_occ  = {1'b0, stage_cnt} + {2'b0, inflight};
  assign ram_rden   = !rst && (ram_cnt != '0) &&
                      (stage_occ < 3'(STAGE_DEPTH) + {2'b0, pop});

  assign ram_wren   = push;
  assign ram_wrAddr = wr_ptr;
  assign ram_datain = din;
  assign ram_rdAddr = rd_ptr;

  assign full        = (ram_cnt == RAM_FULL);
  assign almost_full = (count >= AF_LEVEL);
  assign empty       = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      count    <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (ram_rden) rd_ptr <= rd_ptr + 1'b1;
      inflight <= ram_rden;
      case ({push, ram_rden})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
      // Total occupancy only moves on the stream handshakes.
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  stream_skid_buf2 #(
    .C_DATA_WIDTH(C_DATA_WIDTH)
  ) u_stage (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (inflight),
    .wr_data  (ram_dataout),
    .rd_valid (dout_valid),
    .rd_data  (dout),
    .rd_ready (dout_ready),
    .cnt      (stage_cnt)
  );

endmodule

// File: tb/tb_bram_stream_fifo_ctrl.sv
// Bench for bram_stream_fifo_ctrl: RAM model plus queue-based reference of the stream.
module tb_bram_stream_fifo_ctrl;

  localparam int DW    = 64;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int AF    = DEPTH - 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din_valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_ready;
  logic          dout_valid;
  logic [DW-1:0] dout;
  logic          dout_ready = 1'b0;
  logic [AW-1:0] ram_wrAddr;
  logic [DW-1:0] ram_datain;
  logic          ram_wren;
  logic [AW-1:0] ram_rdAddr;
  logic          ram_rden;
  logic [DW-1:0] ram_dataout = '0;
  logic [AW+1:0] count;
  logic          full;
  logic          almost_full;
  logic          empty;

  bram_stream_fifo_ctrl #(
    .C_DATA_WIDTH (DW),
    .C_RAM_DEPTH  (DEPTH),
    .C_ALMOST_FULL(AF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .dout_valid (dout_valid),
    .dout       (dout),
    .dout_ready (dout_ready),
    .ram_wrAddr (ram_wrAddr),
    .ram_datain (ram_datain),
    .ram_wren   (ram_wren),
    .ram_rdAddr (ram_rdAddr),
    .ram_rden   (ram_rden),
    .ram_dataout(ram_dataout),
    .count      (count),
    .full       (full),
    .almost_full(almost_full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_wrAddr] <= ram_datain;
    if (ram_rden) ram_dataout <= ram_mem[ram_rdAddr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: sb holds every accepted, not yet consumed word in order;
  // ram_occ is words written to RAM and not yet read out of it.
  logic [DW-1:0] sb[$];
  int            ram_occ = 0;
  int            wr_n = 0;
  int            rd_n = 0;
  bit            infl_m = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_dout = '0;
  int            n_push = 0;
  int            n_pop = 0;

  logic          obs_dv, obs_rden, obs_wren, obs_full, obs_af, obs_empty, obs_dready;
  logic [DW-1:0] obs_dout;
  logic [AW-1:0] obs_wraddr, obs_rdaddr;
  logic [AW+1:0] obs_count;

  task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit dv, input logic [DW-1:0] d, input bit dr);
    int stage_m;
    bit pop_m, push_m, rden_m;
    @(negedge clk);
    din_valid  = dv;
    din        = d;
    dout_ready = dr;
    #1;
    stage_m = sb.size() - ram_occ - int'(infl_m);
    pop_m   = (stage_m != 0) && dr;
    push_m  = dv && (ram_occ != DEPTH);
    rden_m  = (ram_occ != 0) && (stage_m + int'(infl_m) - int'(pop_m) < 2);
    check_val("din_ready", din_ready, ram_occ != DEPTH);
    check_val("full", full, ram_occ == DEPTH);
    check_val("count", count, sb.size());
    check_val("empty", empty, sb.size() == 0);
    check_val("almost_full", almost_full, sb.size() >= AF);
    check_val("ram_wren", ram_wren, push_m);
    check_val("ram_wrAddr", ram_wrAddr, wr_n % DEPTH);
    check_val("ram_rden", ram_rden, rden_m);
    check_val("ram_rdAddr", ram_rdAddr, rd_n % DEPTH);
    check_val("dout_valid", dout_valid, stage_m != 0);
    if (stage_m != 0) check_val("dout", dout, sb[0]);
    if (prev_stall)   check_val("dout_hold", dout, prev_dout);
    if (push_m)       check_val("ram_datain", ram_datain, d);
    obs_dv     = dout_valid;
    obs_dout   = dout;
    obs_rden   = ram_rden;
    obs_wren   = ram_wren;
    obs_wraddr = ram_wrAddr;
    obs_rdaddr = ram_rdAddr;
    obs_full   = full;
    obs_af     = almost_full;
    obs_empty  = empty;
    obs_count  = count;
    obs_dready = din_ready;
    prev_stall = (stage_m != 0) && !dr;
    prev_dout  = dout;
    @(posedge clk);
    if (pop_m) begin
      void'(sb.pop_front());
      n_pop++;
    end
    if (push_m) begin
      sb.push_back(d);
      n_push++;
      wr_n++;
      ram_occ++;
    end
    if (rden_m) begin
      ram_occ--;
      rd_n++;
    end
    infl_m = rden_m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    din_valid  = 1'b1;
    din        = '1;
    dout_ready = 1'b0;
    #1;
    check_val("rst_din_ready", din_ready, 1'b0);
    check_val("rst_ram_wren", ram_wren, 1'b0);
    check_val("rst_ram_rden", ram_rden, 1'b0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    din_valid = 1'b0;
    sb.delete();
    ram_occ    = 0;
    wr_n       = 0;
    rd_n       = 0;
    infl_m     = 1'b0;
    prev_stall = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p, bubbles, fulls, af_first, cycles;

    // Reset state
    do_reset();
    check_val("reset_dout_valid", dout_valid, 1'b0);
    check_val("reset_count", count, 0);
    check_val("reset_empty", empty, 1'b1);
    check_val("reset_full", full, 1'b0);
    check_val("reset_almost_full", almost_full, 1'b0);

    // Single word: write, read one cycle later, show-ahead two edges after the push
    cyc(1'b1, 64'hA5, 1'b1);
    check_val("single_wren", obs_wren, 1'b1);
    check_val("single_wraddr", obs_wraddr, 0);
    cyc(1'b0, '0, 1'b1);
    check_val("single_rden", obs_rden, 1'b1);
    check_val("single_rdaddr", obs_rdaddr, 0);
    check_val("single_count1", obs_count, 1);
    cyc(1'b0, '0, 1'b1);
    check_val("single_dv_early", obs_dv, 1'b0);
    check_val("single_count2", obs_count, 1);
    cyc(1'b0, '0, 1'b1);
    check_val("single_dv", obs_dv, 1'b1);
    check_val("single_dout", obs_dout, 64'hA5);
    cyc(1'b0, '0, 1'b1);
    check_val("single_count_after", obs_count, 0);
    check_val("single_empty_after", obs_empty, 1'b1);

    // Streaming: 1000 words, no bubbles after fill latency, never full
    do_reset();
    p = n_pop; bubbles = 0; fulls = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b1, DW'(i), 1'b1);
      if (i >= 3 && !obs_dv) bubbles++;
      if (obs_full) fulls++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b1);
      if (!obs_dv) bubbles++;
    end
    check_val("stream_words", n_pop - p, 1000);
    check_val("stream_bubbles", bubbles, 0);
    check_val("stream_full_seen", fulls, 0);

    // Fill to full with the consumer stalled, then drain
    do_reset();
    p = n_push; af_first = -1;
    for (int i = 0; i < 520; i++) begin
      cyc(1'b1, rnd64(), 1'b0);
      if (obs_af && af_first < 0) af_first = int'(obs_count);
    end
    check_val("fill_accepted", n_push - p, 514);
    check_val("fill_full", obs_full, 1'b1);
    check_val("fill_din_ready", obs_dready, 1'b0);
    check_val("fill_count", obs_count, 514);
    check_val("fill_af_threshold", af_first, 508);
    p = n_pop;
    for (int i = 0; i < 520; i++) cyc(1'b0, '0, 1'b1);
    check_val("drain_words", n_pop - p, 514);
    check_val("drain_empty", obs_empty, 1'b1);

    // Pointer wrap-around
    do_reset();
    for (int i = 0; i < 510; i++) cyc(1'b1, DW'(i), 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, DW'(1000 + k), 1'b1);
      check_val("wrap_wren", obs_wren, 1'b1);
      check_val("wrap_wraddr", obs_wraddr, (510 + k) % DEPTH);
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
    check_val("wrap_empty", obs_empty, 1'b1);

    // Random backpressure on both sides
    do_reset();
    p = n_pop; cycles = 0;
    while ((n_pop - p) < 10000 && cycles < 40000) begin
      cyc(1'($urandom_range(0, 1)), rnd64(), 1'($urandom_range(0, 1)));
      cycles++;
    end
    check_val("rand_words", (n_pop - p) >= 10000, 1'b1);
    for (int i = 0; i < 1100; i++) cyc(1'b0, '0, 1'b1);
    check_val("rand_drained", obs_empty, 1'b1);

    // Reset with words stored and a RAM read in flight
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(64'h100 + i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b1, DW'(64'h105), 1'b1);
    check_val("midrst_rden", obs_rden, 1'b1);
    do_reset();
    check_val("midrst_dout_valid", dout_valid, 1'b0);
    check_val("midrst_count", count, 0);
    check_val("midrst_empty", empty, 1'b1);
    cyc(1'b1, DW'(1), 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    check_val("midrst_no_stale", obs_dv, 1'b0);
    cyc(1'b0, '0, 1'b1);
    check_val("midrst_first_dv", obs_dv, 1'b1);
    check_val("midrst_first_word", obs_dout, 1);
    cyc(1'b0, '0, 1'b1);
    check_val("midrst_final_empty", obs_empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
